// File: rtl/pwm3_ctrl_pkg.sv
// Shared types and default timing for the three-phase PWM leg controller.
// The PRECHARGE state is built only when PWM3_PRECHARGE_EN is defined.
package pwm3_ctrl_pkg;

  localparam int DUTY_W        = 16;
  localparam int PERIOD_DEF    = 16000;
  localparam int DEAD_DEF      = 50;
  localparam int PRECHARGE_DEF = 8000;
  localparam int MIN_PULSE_DEF = 640;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Clamp to full scale, then snap short pulses to a rail.
  function automatic logic [DUTY_W-1:0] duty_snap(
    input logic [DUTY_W-1:0] d,
    input int                period,
    input int                min_pulse
  );
    int v;
    v = int'(d);
    if (v > period) v = period;
    if (v < min_pulse) v = 0;
    else if (v > period - min_pulse) v = period;
    return DUTY_W'(v);
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// One inverter leg: turns the high/low reference into active-low gates
// with a both-off dead window on every reference edge.
module pwm_deadtime
  import pwm3_ctrl_pkg::*;
#(
  parameter int DEAD = DEAD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hi_ref,
  output logic gate_hi,
  output logic gate_lo
);

  localparam int CW = $clog2(DEAD + 1);

  logic          ref_q;
  logic [CW-1:0] cnt_q;
  logic          hi_q;
  logic          lo_q;

  // Out of RUN the leg rests in the low-on condition with both gates off.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      ref_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= 1'b1;
      lo_q  <= 1'b1;
    end else if (hi_ref != ref_q) begin
      ref_q <= hi_ref;
      cnt_q <= CW'(DEAD - 1);
      hi_q  <= 1'b1;
      lo_q  <= 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
      hi_q  <= 1'b1;
      lo_q  <= 1'b1;
    end else begin
      hi_q  <= ~ref_q;
      lo_q  <= ref_q;
    end
  end

  assign gate_hi = hi_q;
  assign gate_lo = lo_q;

endmodule

// File: rtl/pwm3_leg_ctrl.sv
// Three-phase PWM controller: FSM, carrier, duty buffers and fault latch.
// Define PWM3_PRECHARGE_EN to build the bootstrap PRECHARGE state.
module pwm3_leg_ctrl
  import pwm3_ctrl_pkg::*;
#(
  parameter int PERIOD        = PERIOD_DEF,
  parameter int DEAD          = DEAD_DEF,
  parameter int PRECHARGE_CYC = PRECHARGE_DEF,
  parameter int MIN_PULSE     = MIN_PULSE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fault_in,
  input  logic              fault_clr,
  input  logic              duty_load,
  input  logic [DUTY_W-1:0] duty_a,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic [DUTY_W-1:0] duty_c,
  output logic [2:0]        gate_hi,
  output logic [2:0]        gate_lo,
  output logic              period_start,
  output logic [1:0]        state,
  output logic              fault_latched
);

  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);

  state_e                 state_q;
  logic [DUTY_W-1:0]      carrier_q;
  logic                   ps_q;
  logic                   flt_q;
  logic [2:0][DUTY_W-1:0] pend_q;
  logic [2:0][DUTY_W-1:0] act_q;
  logic [2:0][DUTY_W-1:0] snap;
  logic [2:0]             hi_ref;
  logic [2:0]             dt_hi;
  logic [2:0]             dt_lo;
  logic                   run_go;
  logic                   xfer;
  logic                   enter_run;

`ifdef PWM3_PRECHARGE_EN
  localparam int PCW = $clog2(PRECHARGE_CYC + 1);
  logic [PCW-1:0] pre_cnt_q;
  logic           pre_q;
  logic           pre_done;

  assign pre_done  = pre_cnt_q == PCW'(PRECHARGE_CYC - 1);
  assign enter_run = (state_q == ST_PRE) && enable
                     && !fault_in && pre_done;
`else
  assign enter_run = (state_q == ST_IDLE) && enable
                     && !fault_in;
`endif

  assign run_go = (state_q == ST_RUN) && enable && !fault_in;
  assign xfer   = run_go && (carrier_q == LAST);

  assign snap[0] = duty_snap(duty_a, PERIOD, MIN_PULSE);
  assign snap[1] = duty_snap(duty_b, PERIOD, MIN_PULSE);
  assign snap[2] = duty_snap(duty_c, PERIOD, MIN_PULSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      carrier_q <= '0;
      ps_q      <= 1'b0;
      flt_q     <= 1'b0;
`ifdef PWM3_PRECHARGE_EN
      pre_cnt_q <= '0;
      pre_q     <= 1'b0;
`endif
    end else if (fault_in) begin
      state_q   <= ST_FAULT;
      carrier_q <= '0;
      ps_q      <= 1'b0;
      flt_q     <= 1'b1;
`ifdef PWM3_PRECHARGE_EN
      pre_cnt_q <= '0;
      pre_q     <= 1'b0;
`endif
    end else begin
      ps_q <= 1'b0;
`ifdef PWM3_PRECHARGE_EN
      pre_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
`ifdef PWM3_PRECHARGE_EN
            state_q   <= ST_PRE;
            pre_cnt_q <= '0;
            pre_q     <= 1'b1;
`else
            state_q   <= ST_RUN;
            carrier_q <= '0;
            ps_q      <= 1'b1;
`endif
          end
        end
        ST_PRE: begin
`ifdef PWM3_PRECHARGE_EN
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (pre_done) begin
            state_q   <= ST_RUN;
            carrier_q <= '0;
            ps_q      <= 1'b1;
          end else begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
            pre_q     <= 1'b1;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_RUN: begin
          if (!enable) begin
            state_q   <= ST_IDLE;
            carrier_q <= '0;
          end else if (carrier_q == LAST) begin
            carrier_q <= '0;
            ps_q      <= 1'b1;
          end else begin
            carrier_q <= carrier_q + 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state_q <= ST_IDLE;
            flt_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  // A load landing on the transfer edge goes straight to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      if (duty_load) pend_q <= snap;
      if (xfer || enter_run)
        act_q <= duty_load ? snap : pend_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_leg
    assign hi_ref[g] = carrier_q < act_q[g];

    pwm_deadtime #(
      .DEAD(DEAD)
    ) u_dt (
      .clk    (clk),
      .rst    (rst),
      .run    (run_go),
      .hi_ref (hi_ref[g]),
      .gate_hi(dt_hi[g]),
      .gate_lo(dt_lo[g])
    );
  end

  // Bit 0 = leg a, bit 1 = leg b, bit 2 = leg c.
  assign gate_hi = dt_hi;
`ifdef PWM3_PRECHARGE_EN
  assign gate_lo = dt_lo & ~{3{pre_q}};
`else
  assign gate_lo = dt_lo;
`endif

  assign period_start  = ps_q;
  assign state         = state_q;
  assign fault_latched = flt_q;

endmodule

// File: tb/tb_pwm3_leg_ctrl.sv
// Directed bench for pwm3_leg_ctrl at reduced timing
// (PERIOD 100, DEAD 4, PRECHARGE_CYC 20, MIN_PULSE 2).
module tb_pwm3_leg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fault_in;
  logic        fault_clr;
  logic        duty_load;
  logic [15:0] duty_a;
  logic [15:0] duty_b;
  logic [15:0] duty_c;
  logic [2:0]  gate_hi;
  logic [2:0]  gate_lo;
  logic        period_start;
  logic [1:0]  state;
  logic        fault_latched;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;
  int hi_cnt[3];
  int lo_cnt[3];
  int off_cnt[3];
  int ps_cnt;

`ifdef PWM3_PRECHARGE_EN
  localparam int EXP_PRE = 20;
`else
  localparam int EXP_PRE = 0;
`endif

  pwm3_leg_ctrl #(
    .PERIOD       (100),
    .DEAD         (4),
    .PRECHARGE_CYC(20),
    .MIN_PULSE    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .duty_load    (duty_load),
    .duty_a       (duty_a),
    .duty_b       (duty_b),
    .duty_c       (duty_c),
    .gate_hi      (gate_hi),
    .gate_lo      (gate_lo),
    .period_start (period_start),
    .state        (state),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if ((~gate_hi & ~gate_lo) != 3'b000) overlap++;

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Samples one carrier period from carrier 0; optional load at sample ld_at.
  task automatic measure(input int ld_at,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [15:0] c);
    bit ok;
    wait_ps(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL period_sync: period_start=%b required 1",
               period_start);
    end
    ps_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      hi_cnt[i]  = 0;
      lo_cnt[i]  = 0;
      off_cnt[i] = 0;
    end
    for (int k = 0; k < 100; k++) begin
      if (period_start === 1'b1) ps_cnt++;
      for (int i = 0; i < 3; i++) begin
        if (gate_hi[i] === 1'b0) hi_cnt[i]++;
        if (gate_lo[i] === 1'b0) lo_cnt[i]++;
        if (gate_hi[i] === 1'b1 && gate_lo[i] === 1'b1)
          off_cnt[i]++;
      end
      if (k == ld_at) begin
        duty_a    = a;
        duty_b    = b;
        duty_c    = c;
        duty_load = 1'b1;
      end
      if (k == ld_at + 1) duty_load = 1'b0;
      @(negedge clk);
    end
    duty_load = 1'b0;
  endtask

  task automatic check_legs(input string nm, input int eh,
                            input int el, input int eo);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hi_cnt[i] !== eh || lo_cnt[i] !== el
          || off_cnt[i] !== eo) begin
        errors++;
        $display("FAIL %s leg%0d: hi/lo/off=%0d/%0d/%0d required %0d/%0d/%0d",
                 nm, i, hi_cnt[i], lo_cnt[i], off_cnt[i], eh, el, eo);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    fault_in  = 1'b0;
    fault_clr = 1'b0;
    duty_load = 1'b0;
    duty_a    = '0;
    duty_b    = '0;
    duty_c    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (gate_hi !== 3'b111 || gate_lo !== 3'b111) begin
      errors++;
      $display("FAIL reset_gates: hi=%b lo=%b required 111/111",
               gate_hi, gate_lo);
    end
    checks++;
    if (state !== 2'd0 || period_start !== 1'b0
        || fault_latched !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: st=%0d ps=%b flt=%b required 0/0/0",
               state, period_start, fault_latched);
    end
  endtask

  task automatic test_precharge();
    int n;
    int bad;
    duty_a    = 16'd50;
    duty_b    = 16'd50;
    duty_c    = 16'd50;
    duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    enable    = 1'b1;
    @(negedge clk);
    n   = 0;
    bad = 0;
    while (state === 2'd1 && n < 100) begin
      if (gate_lo !== 3'b000 || gate_hi !== 3'b111) bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== EXP_PRE) begin
      errors++;
      $display("FAIL pre_len: cycles=%0d required %0d", n, EXP_PRE);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pre_gates: bad samples=%0d required 0", bad);
    end
    checks++;
    if (state !== 2'd2 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: st=%0d ps=%b required 2/1",
               state, period_start);
    end
  endtask

  task automatic test_pwm50();
    measure(-1, '0, '0, '0);
    checks++;
    if (hi_cnt[0] !== 46 || lo_cnt[0] !== 45) begin
      errors++;
      $display("FAIL first_period: hi=%0d lo=%0d required 46/45",
               hi_cnt[0], lo_cnt[0]);
    end
    measure(-1, '0, '0, '0);
    check_legs("duty50", 46, 46, 8);
    checks++;
    if (ps_cnt !== 1) begin
      errors++;
      $display("FAIL ps_count: pulses=%0d required 1", ps_cnt);
    end
  endtask

  task automatic test_duty_update();
    measure(10, 16'd30, 16'd30, 16'd30);
    check_legs("load_mid_old", 46, 46, 8);
    measure(-1, '0, '0, '0);
    check_legs("load_mid_new", 26, 66, 8);
    measure(99, 16'd70, 16'd70, 16'd70);
    check_legs("load_last_old", 26, 66, 8);
    measure(-1, '0, '0, '0);
    check_legs("load_last_new", 66, 26, 8);
  endtask

  task automatic test_clamp();
    measure(50, 16'd1, 16'd99, 16'd150);
    measure(-1, '0, '0, '0);
    measure(-1, '0, '0, '0);
    checks++;
    if (hi_cnt[0] !== 0 || lo_cnt[0] !== 100 || off_cnt[0] !== 0) begin
      errors++;
      $display("FAIL clamp_a: hi/lo/off=%0d/%0d/%0d required 0/100/0",
               hi_cnt[0], lo_cnt[0], off_cnt[0]);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (hi_cnt[i] !== 100 || lo_cnt[i] !== 0 || off_cnt[i] !== 0) begin
        errors++;
        $display("FAIL clamp_leg%0d: hi/lo/off=%0d/%0d/%0d required 100/0/0",
                 i, hi_cnt[i], lo_cnt[i], off_cnt[i]);
      end
    end
  endtask

  task automatic test_fault();
    repeat (10) @(negedge clk);
    fault_in = 1'b1;
    @(negedge clk);
    checks++;
    if (gate_hi !== 3'b111 || gate_lo !== 3'b111) begin
      errors++;
      $display("FAIL fault_gates: hi=%b lo=%b required 111/111",
               gate_hi, gate_lo);
    end
    checks++;
    if (state !== 2'd3 || fault_latched !== 1'b1) begin
      errors++;
      $display("FAIL fault_state: st=%0d flt=%b required 3/1",
               state, fault_latched);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL clr_blocked: st=%0d required 3", state);
    end
    fault_in  = 1'b0;
    fault_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd3 || fault_latched !== 1'b1) begin
      errors++;
      $display("FAIL fault_hold: st=%0d flt=%b required 3/1",
               state, fault_latched);
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++;
    if (state !== 2'd0 || fault_latched !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: st=%0d flt=%b required 0/0",
               state, fault_latched);
    end
  endtask

  task automatic test_disable_reset();
    bit ok;
    duty_a    = 16'd50;
    duty_b    = 16'd50;
    duty_c    = 16'd50;
    duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    wait_ps(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rerun_sync: period_start=%b required 1",
               period_start);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (gate_hi !== 3'b111 || gate_lo !== 3'b111) begin
      errors++;
      $display("FAIL dead_window: hi=%b lo=%b required 111/111",
               gate_hi, gate_lo);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (gate_hi !== 3'b111 || gate_lo !== 3'b111 || state !== 2'd0) begin
      errors++;
      $display("FAIL disable: hi=%b lo=%b st=%0d required 111/111/0",
               gate_hi, gate_lo, state);
    end
    enable = 1'b1;
    repeat (6) @(negedge clk);
`ifdef PWM3_PRECHARGE_EN
    checks++;
    if (state !== 2'd1 || gate_lo !== 3'b000) begin
      errors++;
      $display("FAIL mid_pre: st=%0d lo=%b required 1/000",
               state, gate_lo);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gate_hi !== 3'b111 || gate_lo !== 3'b111 || state !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid: hi=%b lo=%b st=%0d required 111/111/0",
               gate_hi, gate_lo, state);
    end
    rst    = 1'b0;
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL shoot_through: samples=%0d required 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_precharge();
    test_pwm50();
    test_duty_update();
    test_clamp();
    test_fault();
    test_disable_reset();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
